// File: rtl/alu_pkg.sv
// Shared encodings for the execute unit: ALU func codes, mul/div op codes
// and the mul/div engine state type.
package alu_pkg;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_XOR   = 4'b0101;
   localparam logic [3:0] ALU_LUI   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;
   localparam logic [3:0] ALU_SUB   = 4'b1010;
   localparam logic [3:0] ALU_SLTU  = 4'b1011;
   localparam logic [3:0] ALU_SLT   = 4'b1100;
   localparam logic [3:0] ALU_XNOR  = 4'b1101;

   localparam logic [2:0] MD_NONE  = 3'b000;
   localparam logic [2:0] MD_MULT  = 3'b001;
   localparam logic [2:0] MD_MULTU = 3'b010;
   localparam logic [2:0] MD_DIV   = 3'b011;
   localparam logic [2:0] MD_DIVU  = 3'b100;
   localparam logic [2:0] MD_MTHI  = 3'b101;
   localparam logic [2:0] MD_MTLO  = 3'b110;
   localparam logic [2:0] MD_RSVD  = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX,
      S_DONE
   } md_state_t;

endpackage

// File: rtl/alu_muldiv_if.sv
// EX-stage bus of the execute unit: ALU operands/result plus the mul/div
// start/busy/done handshake and the architectural HI/LO view.
interface alu_muldiv_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [3:0]       func;
   logic [WIDTH-1:0] out;
   logic [2:0]       md_op;
   logic             md_start;
   logic             md_busy;
   logic             md_done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output in1, in2, func, md_op, md_start,
      input  out, md_busy, md_done, hi, lo
   );

   modport slave (
      input  in1, in2, func, md_op, md_start,
      output out, md_busy, md_done, hi, lo
   );
endinterface

// File: rtl/alu_core.sv
// Single-cycle integer ALU. Subtract and compares share one adder fed with
// the conditionally inverted B operand and func[3] as carry-in.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int LUI_SHIFT = WIDTH / 2
) (
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [3:0]       func,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic             ovf;
   logic             slt;
   logic             sltu;

   assign b_eff = func[3] ? ~in2 : in2;
   assign sum   = {1'b0, in1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, func[3]};
   // Overflow from the actual adder inputs keeps MIN vs MAX correct.
   assign ovf   = (in1[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
   assign slt   = sum[WIDTH-1] ^ ovf;
   assign sltu  = ~sum[WIDTH];

   always_comb begin
      out = b_eff;
      case (func)
         ALU_AND:          out = in1 & b_eff;
         ALU_OR:           out = in1 | b_eff;
         ALU_ADD, ALU_SUB: out = sum[WIDTH-1:0];
         ALU_SLTU:         out = {{(WIDTH-1){1'b0}}, sltu};
         ALU_SLT:          out = {{(WIDTH-1){1'b0}}, slt};
         ALU_XOR, ALU_XNOR: out = in1 ^ b_eff;
         ALU_LUI:          out = b_eff << LUI_SHIFT;
         default:          out = b_eff;
      endcase
   end

endmodule

// File: rtl/alu_muldiv.sv
// Execute unit: combinational ALU plus a background iterative mul/div engine
// (one bit per cycle) that owns the HI/LO registers.
module alu_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int LUI_SHIFT = WIDTH / 2
) (
   input  logic          clk,
   input  logic          rst,
   alu_muldiv_if.slave   bus
);

   localparam int CW = $clog2(WIDTH + 1);

   md_state_t         state_q, state_d;
   logic [WIDTH-1:0]  mcand_q, mcand_d;
   logic [WIDTH-1:0]  acc_q, acc_d;
   logic [WIDTH-1:0]  mq_q, mq_d;
   logic [WIDTH-1:0]  dvd_q, dvd_d;
   logic [WIDTH-1:0]  hi_q, hi_d;
   logic [WIDTH-1:0]  lo_q, lo_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              neg_res_q, neg_res_d;
   logic              neg_rem_q, neg_rem_d;
   logic              dz_q, dz_d;
   logic              is_div_q, is_div_d;
   logic              done_q, done_d;

   logic              accept;
   logic              a_neg, b_neg;
   logic [WIDTH-1:0]  abs_a, abs_b;
   logic [WIDTH:0]    mul_sum;
   logic [WIDTH:0]    div_trial;
   logic [2*WIDTH-1:0] prod_raw, prod_fix;

   alu_core #(.WIDTH(WIDTH), .LUI_SHIFT(LUI_SHIFT)) u_core (
      .in1  (bus.in1),
      .in2  (bus.in2),
      .func (bus.func),
      .out  (bus.out)
   );

   assign accept    = bus.md_start && (state_q == S_IDLE);
   assign a_neg     = bus.in1[WIDTH-1];
   assign b_neg     = bus.in2[WIDTH-1];
   assign abs_a     = a_neg ? -bus.in1 : bus.in1;
   assign abs_b     = b_neg ? -bus.in2 : bus.in2;
   assign mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
   assign div_trial = {acc_q, mq_q[WIDTH-1]} - {1'b0, mcand_q};
   assign prod_raw  = {acc_q, mq_q};
   assign prod_fix  = neg_res_q ? -prod_raw : prod_raw;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         mcand_q   <= '0;
         acc_q     <= '0;
         mq_q      <= '0;
         dvd_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         cnt_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         is_div_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         mq_q      <= mq_d;
         dvd_q     <= dvd_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         cnt_q     <= cnt_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         is_div_q  <= is_div_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept && (bus.md_op == MD_MULT || bus.md_op == MD_MULTU))
               state_d = S_MUL;
            else if (accept && (bus.md_op == MD_DIV || bus.md_op == MD_DIVU))
               state_d = S_DIV;
         end
         S_MUL, S_DIV: if (cnt_q == CW'(1)) state_d = S_FIX;
         S_FIX:   state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      mq_d      = mq_q;
      dvd_d     = dvd_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      cnt_d     = cnt_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      is_div_d  = is_div_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: if (accept) begin
            acc_d     = '0;
            cnt_d     = CW'(WIDTH);
            neg_res_d = 1'b0;
            neg_rem_d = 1'b0;
            dz_d      = (bus.in2 == '0);
            dvd_d     = bus.in1;
            case (bus.md_op)
               MD_MULT: begin
                  mcand_d = abs_a; mq_d = abs_b; is_div_d = 1'b0;
                  neg_res_d = a_neg ^ b_neg;
               end
               MD_MULTU: begin
                  mcand_d = bus.in1; mq_d = bus.in2; is_div_d = 1'b0;
               end
               // Divisor sits in mcand, dividend shifts out of mq as quotient shifts in.
               MD_DIV: begin
                  mcand_d = abs_b; mq_d = abs_a; is_div_d = 1'b1;
                  neg_res_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
               end
               MD_DIVU: begin
                  mcand_d = bus.in2; mq_d = bus.in1; is_div_d = 1'b1;
               end
               MD_MTHI: begin hi_d = bus.in1; done_d = 1'b1; end
               MD_MTLO: begin lo_d = bus.in1; done_d = 1'b1; end
               default: ;
            endcase
         end
         S_MUL: begin
            acc_d = mul_sum[WIDTH:1];
            mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
            cnt_d = cnt_q - CW'(1);
         end
         S_DIV: begin
            if (!div_trial[WIDTH]) begin
               acc_d = div_trial[WIDTH-1:0];
               mq_d  = {mq_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
               mq_d  = {mq_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
         end
         // Commit on the edge into DONE so HI/LO are visible while md_done is high.
         S_FIX: begin
            done_d = 1'b1;
            if (!is_div_q) begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end else if (dz_q) begin
               hi_d = dvd_q;
               lo_d = '1;
            end else begin
               hi_d = neg_rem_q ? -acc_q : acc_q;
               lo_d = neg_res_q ? -mq_q : mq_q;
            end
         end
         default: ;
      endcase
   end

   assign bus.md_busy = (state_q != S_IDLE);
   assign bus.md_done = done_q;
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;

endmodule
